// File: rtl/lstm_pkg.sv
// Shared defaults and FSM state encoding for the LSTM input-vector fetch path.
package lstm_pkg;

  localparam int LSTM_WIDTH          = 32;
  localparam int LSTM_NUM            = 45;
  localparam int LSTM_NUM_ITERATIONS = 8;
  localparam int LSTM_NUM_SAMPLES    = 2;
  localparam int LSTM_FRAC           = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/lstm_x_fetch_if.sv
// Memory read port and downstream element stream of the x-vector fetcher.
interface lstm_x_fetch_if
  import lstm_pkg::*;
#(
    parameter int WIDTH = LSTM_WIDTH
);

    // Read is combinational: mem_data answers mem_addr in the same cycle.
    // Stream: a word moves when x_valid && x_ready at a rising edge; once x_valid
    // is high, x_data/x_elem/x_step/x_last hold until that transfer happens.
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] x_data;
    logic [WIDTH-1:0] x_elem;
    logic [WIDTH-1:0] x_step;
    logic             x_valid;
    logic             x_ready;
    logic             x_last;

    modport master (
        output mem_addr,
        input  mem_data,
        output x_data,
        output x_elem,
        output x_step,
        output x_valid,
        output x_last,
        input  x_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  x_data,
        input  x_elem,
        input  x_step,
        input  x_valid,
        input  x_last,
        output x_ready
    );

endinterface

// File: rtl/lstm_x_idx_cnt.sv
// Nested element/step counter: elem runs fastest, step advances on elem wrap,
// and the pair parks at the terminal position until cleared.
module lstm_x_idx_cnt
  import lstm_pkg::*;
#(
    parameter int WIDTH          = LSTM_WIDTH,
    parameter int NUM            = LSTM_NUM,
    parameter int NUM_ITERATIONS = LSTM_NUM_ITERATIONS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] elem,
    output logic [WIDTH-1:0] step,
    output logic             last
);

    localparam logic [WIDTH-1:0] ELEM_MAX = WIDTH'(NUM - 1);
    localparam logic [WIDTH-1:0] STEP_MAX = WIDTH'(NUM_ITERATIONS - 1);

    logic [WIDTH-1:0] elem_q, elem_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             last_w;

    assign last_w = (elem_q == ELEM_MAX) && (step_q == STEP_MAX);

    always_comb begin
        elem_d = elem_q;
        step_d = step_q;
        if (clr) begin
            elem_d = '0;
            step_d = '0;
        end else if (en && !last_w) begin
            if (elem_q == ELEM_MAX) begin
                elem_d = '0;
                step_d = step_q + 1'b1;
            end else begin
                elem_d = elem_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q <= '0;
            step_q <= '0;
        end else begin
            elem_q <= elem_d;
            step_q <= step_d;
        end
    end

    assign elem = elem_q;
    assign step = step_q;
    assign last = last_w;

endmodule

// File: rtl/lstm_x_fetch.sv
// Streams one sample (NUM_ITERATIONS timesteps of NUM words) from the input memory.
// Define X_FETCH_BIAS_EN to replace element 0 of every timestep with 1.0.
module lstm_x_fetch
  import lstm_pkg::*;
#(
    parameter int WIDTH          = LSTM_WIDTH,
    parameter int NUM            = LSTM_NUM,
    parameter int NUM_ITERATIONS = LSTM_NUM_ITERATIONS,
    parameter int NUM_SAMPLES    = LSTM_NUM_SAMPLES,
    parameter int FRAC           = LSTM_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      sample_sel,
    output logic                  busy,
    output logic                  done,
    output fetch_state_e          state_dbg,
    lstm_x_fetch_if.master        xs
);

`ifdef X_FETCH_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] NUM_W    = WIDTH'(NUM);
    localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(NUM * NUM_ITERATIONS);
    localparam logic [WIDTH-1:0] NSAMP_W  = WIDTH'(NUM_SAMPLES);
    localparam logic [WIDTH-1:0] BIAS_ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    fetch_state_e     state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             x_valid_q, x_valid_d;
    logic             x_last_q, x_last_d;
    logic [WIDTH-1:0] x_data_q, x_data_d;
    logic [WIDTH-1:0] x_elem_q, x_elem_d;
    logic [WIDTH-1:0] x_step_q, x_step_d;

    logic             accept;
    logic             hs;
    logic             load;
    logic [WIDTH-1:0] cnt_elem;
    logic [WIDTH-1:0] cnt_step;
    logic             cnt_last;

    assign accept = (state_q == IDLE) && start && (sample_sel < NSAMP_W);
    assign hs     = x_valid_q && xs.x_ready;
    // pending_q marks that the counter still points at an unfetched word.
    assign load   = (state_q == STREAM) && pending_q && (!x_valid_q || xs.x_ready);

    lstm_x_idx_cnt #(
        .WIDTH          (WIDTH),
        .NUM            (NUM),
        .NUM_ITERATIONS (NUM_ITERATIONS)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (load),
        .elem  (cnt_elem),
        .step  (cnt_step),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pending_d = pending_q;
        base_d    = base_q;
        x_valid_d = x_valid_q;
        x_last_d  = x_last_q;
        x_data_d  = x_data_q;
        x_elem_d  = x_elem_q;
        x_step_d  = x_step_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = STREAM;
                    busy_d    = 1'b1;
                    pending_d = 1'b1;
                    base_d    = sample_sel * STRIDE_W;
                end
            end
            STREAM: begin
                if (load) begin
                    x_valid_d = 1'b1;
                    x_last_d  = cnt_last;
                    x_elem_d  = cnt_elem;
                    x_step_d  = cnt_step;
                    x_data_d  = (BIAS_EN && (cnt_elem == '0)) ? BIAS_ONE : xs.mem_data;
                    pending_d = !cnt_last;
                end else if (hs) begin
                    x_valid_d = 1'b0;
                end
                if (hs && x_last_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            base_q    <= '0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
            x_data_q  <= '0;
            x_elem_q  <= '0;
            x_step_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            x_valid_q <= x_valid_d;
            x_last_q  <= x_last_d;
            x_data_q  <= x_data_d;
            x_elem_q  <= x_elem_d;
            x_step_q  <= x_step_d;
        end
    end

    assign xs.mem_addr = (state_q == STREAM) ? (base_q + cnt_step * NUM_W + cnt_elem) : '0;
    assign xs.x_valid  = x_valid_q;
    assign xs.x_last   = x_last_q;
    assign xs.x_data   = x_data_q;
    assign xs.x_elem   = x_elem_q;
    assign xs.x_step   = x_step_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_lstm_x_fetch.sv
// Directed bench for lstm_x_fetch: start-acceptance vector table plus stream,
// stall, mid-stream start and mid-stream reset sequences against a memory model.
module tb_lstm_x_fetch;
  import lstm_pkg::*;

`ifdef X_FETCH_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam int NUM   = 45;
  localparam int ITER  = 8;
  localparam int NSAMP = 2;
  localparam int TOTAL = NUM * ITER;

  typedef struct {
    logic [31:0] sel;
    logic        exp_go;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } start_vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  sample_sel;
  logic         x_ready;
  logic         busy;
  logic         done;
  fetch_state_e state_dbg;

  int total = 0;
  int bad   = 0;
  logic [48:0] exp_q[$];

  lstm_x_fetch_if #(.WIDTH(32)) xif ();

  lstm_x_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sample_sel (sample_sel),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg),
    .xs         (xif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'hDEAD_BEEF;
    if (a >= 32'(TOTAL * NSAMP)) return 32'hBAD0_0BAD;
    return 32'hA500_0000 ^ (a * 32'h0001_0003);
  endfunction

  assign xif.mem_data = mem_word(xif.mem_addr);
  assign xif.x_ready  = x_ready;

  function automatic logic [48:0] exp_item(input logic [31:0] sel, input int s, input int e);
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    addr = sel * 32'(TOTAL) + 32'(s * NUM + e);
    data = (BIAS_EN && e == 0) ? 32'h0001_0000 : mem_word(addr);
    last = (s == ITER - 1) && (e == NUM - 1);
    return {last, 8'(s), 8'(e), data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"},  64'(state_dbg),    64'(IDLE));
    check({tag, "_valid"},  64'(xif.x_valid),  64'd0);
    check({tag, "_data"},   64'(xif.x_data),   64'd0);
    check({tag, "_elem"},   64'(xif.x_elem),   64'd0);
    check({tag, "_step"},   64'(xif.x_step),   64'd0);
    check({tag, "_last"},   64'(xif.x_last),   64'd0);
    check({tag, "_busy"},   64'(busy),         64'd0);
    check({tag, "_done"},   64'(done),         64'd0);
    check({tag, "_addr"},   64'(xif.mem_addr), 64'd0);
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x_ready = 1'b0;
    sample_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input logic [31:0] sel, input bit stall_mode,
                            input bit mid_start, input int abort_at);
    int hs_cnt = 0;
    int valid_cyc = 0;
    int done_cnt = 0;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    bit mid_sent = 1'b0;
    bit last_seen = 1'b0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [49:0] prev_out;
    logic [31:0] prev_addr;
    logic [48:0] got;
    logic [48:0] exp;

    exp_q.delete();
    for (int s = 0; s < ITER; s++)
      for (int e = 0; e < NUM; e++)
        exp_q.push_back(exp_item(sel, s, e));

    sample_sel = sel;
    start = 1'b1;
    x_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("go_state", 64'(state_dbg), 64'(STREAM));
    check("go_busy", 64'(busy), 64'd1);
    check("go_valid_low", 64'(xif.x_valid), 64'd0);
    check("go_addr", 64'(xif.mem_addr), 64'(sel * 32'(TOTAL)));
    @(posedge clk); #1;
    check("first_valid", 64'(xif.x_valid), 64'd1);

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      x_ready = stall_mode ? pat[cyc % 4] : 1'b1;
      if (mid_start && !mid_sent && hs_cnt >= 50) begin
        start = 1'b1;
        sample_sel = sel ^ 32'd1;
        mid_sent = 1'b1;
      end
      if (stalled) begin
        check("stall_hold", 64'({xif.x_valid, xif.x_last, xif.x_step[7:0], xif.x_elem[7:0], xif.x_data}),
              64'(prev_out));
        check("stall_addr", 64'(xif.mem_addr), 64'(prev_addr));
      end
      if (xif.x_valid) valid_cyc++;
      stalled = xif.x_valid && !x_ready;
      prev_out = {xif.x_valid, xif.x_last, xif.x_step[7:0], xif.x_elem[7:0], xif.x_data};
      prev_addr = xif.mem_addr;
      if (xif.x_valid && x_ready) begin
        got = {xif.x_last, xif.x_step[7:0], xif.x_elem[7:0], xif.x_data};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("elem", 64'(got), 64'(exp));
        check("elem_hi_idx", 64'({xif.x_step[31:8], xif.x_elem[31:8]}), 64'd0);
        last_seen = xif.x_last;
        hs_cnt++;
      end
      @(posedge clk); #1;
      if (start) begin
        start = 1'b0;
        check("mid_start_state", 64'(state_dbg), 64'(STREAM));
        check("mid_start_busy", 64'(busy), 64'd1);
      end
      if (done) done_cnt++;
      if (abort_at >= 0 && hs_cnt == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk); #1;
        check_zero("rst_held");
        rst_n = 1'b1;
        x_ready = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          check("post_rst_state", 64'(state_dbg), 64'(IDLE));
          check("post_rst_busy", 64'(busy), 64'd0);
          check("post_rst_valid", 64'(xif.x_valid), 64'd0);
        end
        return;
      end
      if (last_seen) begin
        check("end_done", 64'(done), 64'd1);
        check("end_state", 64'(state_dbg), 64'(DONE));
        check("end_valid", 64'(xif.x_valid), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_addr", 64'(xif.mem_addr), 64'd0);
        fin = 1'b1;
      end
    end

    check("stream_finished", 64'(fin), 64'd1);
    @(posedge clk); #1;
    if (done) done_cnt++;
    check("idle_state", 64'(state_dbg), 64'(IDLE));
    check("done_dropped", 64'(done), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("hs_count", 64'(hs_cnt), 64'(TOTAL));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (!stall_mode) check("throughput", 64'(valid_cyc), 64'(TOTAL));
  endtask

  start_vec_t vecs[5];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_ready = 1'b0;
    sample_sel = '0;
    #1 check_zero("reset");
    do_reset();
    check_zero("after_reset");

    vecs[0] = '{32'd0,          1'b1, 32'd0,   exp_item(32'd0, 0, 0)};
    vecs[1] = '{32'd1,          1'b1, 32'd360, exp_item(32'd1, 0, 0)};
    vecs[2] = '{32'd2,          1'b0, 32'd0,   32'd0};
    vecs[3] = '{32'hFFFF_FFFF,  1'b0, 32'd0,   32'd0};
    vecs[4] = '{32'h8000_0001,  1'b0, 32'd0,   32'd0};

    for (int i = 0; i < 5; i++) begin
      sample_sel = vecs[i].sel;
      start = 1'b1;
      x_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("vec_state", 64'(state_dbg), vecs[i].exp_go ? 64'(STREAM) : 64'(IDLE));
      check("vec_busy", 64'(busy), 64'(vecs[i].exp_go));
      check("vec_addr", 64'(xif.mem_addr), 64'(vecs[i].exp_addr));
      @(posedge clk); #1;
      check("vec_valid", 64'(xif.x_valid), 64'(vecs[i].exp_go));
      check("vec_data", 64'(xif.x_data), 64'(vecs[i].exp_data));
      do_reset();
    end

    run_stream(32'd1, 1'b0, 1'b0, -1);
    run_stream(32'd0, 1'b1, 1'b1, -1);
    run_stream(32'd0, 1'b1, 1'b0, 100);
    run_stream(32'd1, 1'b0, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
